// File: rtl/pcie_tlp_arb_mux_pkg.sv
// Shared types for the packet-aware TLP arbiter/multiplexer.
package pcie_tlp_arb_mux_pkg;

    typedef enum logic {
        StIdle,
        StXfer
    } arb_state_e;

endpackage

// File: rtl/pcie_tlp_arbiter.sv
// Request arbiter: round-robin or fixed priority, pointer advanced on release.
module pcie_tlp_arbiter #(
    parameter int PORTS                 = 2,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 1,
    parameter int CL_PORTS              = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PORTS-1:0]    req_i,
    input  logic                ack_i,
    input  logic [CL_PORTS-1:0] ack_idx_i,
    output logic [PORTS-1:0]    grant_o,
    output logic [CL_PORTS-1:0] grant_enc_o,
    output logic                grant_valid_o
);

    logic [CL_PORTS-1:0] last_q, last_d;
    logic [CL_PORTS-1:0] cand;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_enc_o   = '0;
        grant_o       = '0;
        cand          = '0;
        if (ARB_TYPE_ROUND_ROBIN != 0) begin
            // Search begins one past the last grant, wrapping to port 0.
            for (int k = 1; k <= PORTS; k++) begin
                cand = CL_PORTS'((int'(last_q) + k) % PORTS);
                if (!grant_valid_o && req_i[cand]) begin
                    grant_valid_o = 1'b1;
                    grant_enc_o   = cand;
                end
            end
        end else if (ARB_LSB_HIGH_PRIORITY != 0) begin
            for (int i = 0; i < PORTS; i++) begin
                if (!grant_valid_o && req_i[i]) begin
                    grant_valid_o = 1'b1;
                    grant_enc_o   = CL_PORTS'(i);
                end
            end
        end else begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (!grant_valid_o && req_i[i]) begin
                    grant_valid_o = 1'b1;
                    grant_enc_o   = CL_PORTS'(i);
                end
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_enc_o] = 1'b1;
        end
    end

    assign last_d = ack_i ? ack_idx_i : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CL_PORTS'(PORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pcie_tlp_arb_mux.sv
// Packet-aware TLP arbiter/mux: grant held SOP..EOP, registered output with skid buffer.
module pcie_tlp_arb_mux
    import pcie_tlp_arb_mux_pkg::*;
#(
    parameter int PORTS                 = 2,
    parameter int TLP_DATA_WIDTH        = 256,
    parameter int TLP_STRB_WIDTH        = TLP_DATA_WIDTH / 32,
    parameter int TLP_HDR_WIDTH         = 128,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 1,
    parameter int CL_PORTS              = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*TLP_DATA_WIDTH-1:0] in_tlp_data,
    input  logic [PORTS*TLP_STRB_WIDTH-1:0] in_tlp_strb,
    input  logic [PORTS*TLP_HDR_WIDTH-1:0]  in_tlp_hdr,
    input  logic [PORTS*3-1:0]          in_tlp_bar_id,
    input  logic [PORTS*8-1:0]          in_tlp_func_num,
    input  logic [PORTS*4-1:0]          in_tlp_error,
    input  logic [PORTS-1:0]            in_tlp_valid,
    input  logic [PORTS-1:0]            in_tlp_sop,
    input  logic [PORTS-1:0]            in_tlp_eop,
    output logic [PORTS-1:0]            in_tlp_ready,
    output logic [TLP_DATA_WIDTH-1:0]   out_tlp_data,
    output logic [TLP_STRB_WIDTH-1:0]   out_tlp_strb,
    output logic [TLP_HDR_WIDTH-1:0]    out_tlp_hdr,
    output logic [2:0]                  out_tlp_bar_id,
    output logic [7:0]                  out_tlp_func_num,
    output logic [3:0]                  out_tlp_error,
    output logic                        out_tlp_valid,
    output logic                        out_tlp_sop,
    output logic                        out_tlp_eop,
    input  logic                        out_tlp_ready,
    output logic [CL_PORTS-1:0]         sel_port,
    output logic                        busy
);

    localparam int BeatW = 2 + TLP_DATA_WIDTH + TLP_STRB_WIDTH + TLP_HDR_WIDTH + 3 + 8 + 4;

    arb_state_e          state_q, state_d;
    logic [CL_PORTS-1:0] sel_q, sel_d;
    logic                ready_q, ready_d;
    logic                main_valid_q, main_valid_d;
    logic [BeatW-1:0]    main_q, main_d;
    logic                skid_valid_q, skid_valid_d;
    logic [BeatW-1:0]    skid_q, skid_d;

    logic [PORTS-1:0]    req;
    logic [PORTS-1:0]    grant;
    logic [CL_PORTS-1:0] grant_enc;
    logic                grant_valid;
    logic                ack;
    logic [CL_PORTS-1:0] ack_idx;
    logic                accept;
    logic [CL_PORTS-1:0] mux_idx;
    logic                mux_valid;
    logic                mux_eop;
    logic [BeatW-1:0]    mux_beat;

    assign req = in_tlp_valid & in_tlp_sop;

    pcie_tlp_arbiter #(
        .PORTS                 (PORTS),
        .ARB_TYPE_ROUND_ROBIN  (ARB_TYPE_ROUND_ROBIN),
        .ARB_LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
        .CL_PORTS              (CL_PORTS)
    ) u_arbiter (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .ack_i         (ack),
        .ack_idx_i     (ack_idx),
        .grant_o       (grant),
        .grant_enc_o   (grant_enc),
        .grant_valid_o (grant_valid)
    );

    assign mux_idx   = (state_q == StIdle) ? grant_enc : sel_q;
    assign mux_valid = in_tlp_valid[mux_idx];
    assign mux_eop   = in_tlp_eop[mux_idx];
    assign mux_beat  = {in_tlp_sop[mux_idx], in_tlp_eop[mux_idx],
                        in_tlp_data[int'(mux_idx)*TLP_DATA_WIDTH +: TLP_DATA_WIDTH],
                        in_tlp_strb[int'(mux_idx)*TLP_STRB_WIDTH +: TLP_STRB_WIDTH],
                        in_tlp_hdr[int'(mux_idx)*TLP_HDR_WIDTH +: TLP_HDR_WIDTH],
                        in_tlp_bar_id[int'(mux_idx)*3 +: 3],
                        in_tlp_func_num[int'(mux_idx)*8 +: 8],
                        in_tlp_error[int'(mux_idx)*4 +: 4]};

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        in_tlp_ready = '0;
        accept       = 1'b0;
        ack          = 1'b0;
        ack_idx      = sel_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid && ready_q) begin
                    in_tlp_ready = grant;
                    accept       = 1'b1;
                    sel_d        = grant_enc;
                    if (mux_eop) begin
                        ack     = 1'b1;
                        ack_idx = grant_enc;
                    end else begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                in_tlp_ready[sel_q] = ready_q;
                accept              = ready_q && mux_valid;
                if (accept && mux_eop) begin
                    ack     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A beat accepted while the main register is stalled parks in the skid register.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (main_valid_q && !out_tlp_ready) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_d       = mux_beat;
            end
        end else if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else begin
            main_valid_d = accept;
            if (accept) begin
                main_d = mux_beat;
            end
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            ready_q      <= 1'b0;
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ready_q      <= ready_d;
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign {out_tlp_sop, out_tlp_eop, out_tlp_data, out_tlp_strb, out_tlp_hdr,
            out_tlp_bar_id, out_tlp_func_num, out_tlp_error} = main_q;
    assign out_tlp_valid = main_valid_q;
    assign sel_port      = sel_q;
    assign busy          = (state_q == StXfer);

endmodule

// File: tb/tb_pcie_tlp_arb_mux.sv
// Directed table-driven bench for pcie_tlp_arb_mux: round-robin and fixed-priority instances.
module tb_pcie_tlp_arb_mux;

    localparam int P  = 3;
    localparam int DW = 32;
    localparam int SW = 1;
    localparam int HW = 32;
    localparam int CL = 2;

    typedef struct packed {
        logic [2:0] v;
        logic [2:0] s;
        logic [2:0] e;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       ordy;
        logic [2:0] ir;
        logic       ev;
        logic       es;
        logic       ee;
        logic [7:0] ed;
        logic       eb;
        logic [1:0] esel;
    } vec_t;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [P-1:0]    v_in, s_in, e_in;
    logic [7:0]      d_in [P];
    logic            ordy;
    logic [P*DW-1:0] data_bus;
    logic [P*SW-1:0] strb_bus;
    logic [P*HW-1:0] hdr_bus;
    logic [P*3-1:0]  bar_bus;
    logic [P*8-1:0]  func_bus;
    logic [P*4-1:0]  err_bus;

    always_comb begin
        data_bus = '0;
        strb_bus = '0;
        hdr_bus  = '0;
        bar_bus  = '0;
        func_bus = '0;
        err_bus  = '0;
        for (int i = 0; i < P; i++) begin
            data_bus[i*DW +: DW] = {24'h0, d_in[i]};
            strb_bus[i*SW +: SW] = 1'b1;
            hdr_bus[i*HW +: HW]  = {4{d_in[i]}};
            bar_bus[i*3 +: 3]    = d_in[i][2:0];
            func_bus[i*8 +: 8]   = d_in[i];
            err_bus[i*4 +: 4]    = d_in[i][3:0];
        end
    end

    logic [P-1:0]  rr_ir, fp_ir;
    logic [DW-1:0] rr_data, fp_data;
    logic [SW-1:0] rr_strb, fp_strb;
    logic [HW-1:0] rr_hdr, fp_hdr;
    logic [2:0]    rr_bar, fp_bar;
    logic [7:0]    rr_func, fp_func;
    logic [3:0]    rr_err, fp_err;
    logic          rr_v, rr_s, rr_e, fp_v, fp_s, fp_e;
    logic [CL-1:0] rr_sel, fp_sel;
    logic          rr_busy, fp_busy;

    pcie_tlp_arb_mux #(
        .PORTS                 (P),
        .TLP_DATA_WIDTH        (DW),
        .TLP_STRB_WIDTH        (SW),
        .TLP_HDR_WIDTH         (HW),
        .ARB_TYPE_ROUND_ROBIN  (1),
        .ARB_LSB_HIGH_PRIORITY (1),
        .CL_PORTS              (CL)
    ) u_rr (
        .clk (clk), .rst_n (rst_n),
        .in_tlp_data (data_bus), .in_tlp_strb (strb_bus), .in_tlp_hdr (hdr_bus),
        .in_tlp_bar_id (bar_bus), .in_tlp_func_num (func_bus), .in_tlp_error (err_bus),
        .in_tlp_valid (v_in), .in_tlp_sop (s_in), .in_tlp_eop (e_in), .in_tlp_ready (rr_ir),
        .out_tlp_data (rr_data), .out_tlp_strb (rr_strb), .out_tlp_hdr (rr_hdr),
        .out_tlp_bar_id (rr_bar), .out_tlp_func_num (rr_func), .out_tlp_error (rr_err),
        .out_tlp_valid (rr_v), .out_tlp_sop (rr_s), .out_tlp_eop (rr_e),
        .out_tlp_ready (ordy), .sel_port (rr_sel), .busy (rr_busy)
    );

    pcie_tlp_arb_mux #(
        .PORTS                 (P),
        .TLP_DATA_WIDTH        (DW),
        .TLP_STRB_WIDTH        (SW),
        .TLP_HDR_WIDTH         (HW),
        .ARB_TYPE_ROUND_ROBIN  (0),
        .ARB_LSB_HIGH_PRIORITY (1),
        .CL_PORTS              (CL)
    ) u_fp (
        .clk (clk), .rst_n (rst_n),
        .in_tlp_data (data_bus), .in_tlp_strb (strb_bus), .in_tlp_hdr (hdr_bus),
        .in_tlp_bar_id (bar_bus), .in_tlp_func_num (func_bus), .in_tlp_error (err_bus),
        .in_tlp_valid (v_in), .in_tlp_sop (s_in), .in_tlp_eop (e_in), .in_tlp_ready (fp_ir),
        .out_tlp_data (fp_data), .out_tlp_strb (fp_strb), .out_tlp_hdr (fp_hdr),
        .out_tlp_bar_id (fp_bar), .out_tlp_func_num (fp_func), .out_tlp_error (fp_err),
        .out_tlp_valid (fp_v), .out_tlp_sop (fp_s), .out_tlp_eop (fp_e),
        .out_tlp_ready (ordy), .sel_port (fp_sel), .busy (fp_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic use_fp = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] s, input logic [2:0] e,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic ordy_v, input logic [2:0] ir, input logic ev,
                                input logic es, input logic ee, input logic [7:0] ed,
                                input logic eb, input logic [1:0] esel);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.ordy = ordy_v;
        t.ir = ir; t.ev = ev; t.es = es; t.ee = ee; t.ed = ed; t.eb = eb; t.esel = esel;
        return t;
    endfunction

    task automatic run_vec(input vec_t t, input string tag);
        logic [127:0] act, exp;
        @(negedge clk);
        v_in = t.v; s_in = t.s; e_in = t.e;
        d_in[0] = t.d0; d_in[1] = t.d1; d_in[2] = t.d2;
        ordy = t.ordy;
        #1;
        check({tag, " in_ready"}, 128'(use_fp ? fp_ir : rr_ir), 128'(t.ir));
        @(posedge clk);
        #1;
        if (t.ev) begin
            exp = 128'({t.ev, t.es, t.ee, 24'h0, t.ed, {4{t.ed}}, t.ed[2:0], t.ed, t.ed[3:0],
                        1'b1, t.eb, t.esel});
            if (use_fp)
                act = 128'({fp_v, fp_s, fp_e, fp_data, fp_hdr, fp_bar, fp_func, fp_err,
                            fp_strb, fp_busy, fp_sel});
            else
                act = 128'({rr_v, rr_s, rr_e, rr_data, rr_hdr, rr_bar, rr_func, rr_err,
                            rr_strb, rr_busy, rr_sel});
        end else begin
            exp = 128'({1'b0, t.eb, t.esel});
            act = use_fp ? 128'({fp_v, fp_busy, fp_sel}) : 128'({rr_v, rr_busy, rr_sel});
        end
        check({tag, " out"}, act, exp);
    endtask

    task automatic idle_inputs();
        v_in = '0; s_in = '0; e_in = '0;
        d_in[0] = '0; d_in[1] = '0; d_in[2] = '0;
        ordy = 1'b1;
    endtask

    vec_t rr_tbl[$];
    vec_t fp_tbl[$];

    initial begin
        // v, s, e, d0, d1, d2, ordy, ir, ev, es, ee, ed, busy, sel
        rr_tbl.push_back(mk(3'b010, 3'b010, 3'b000, 8'h00, 8'h11, 8'h00, 1, 3'b010, 1, 1, 0, 8'h11, 1, 1));
        rr_tbl.push_back(mk(3'b010, 3'b000, 3'b000, 8'h00, 8'h12, 8'h00, 1, 3'b010, 1, 0, 0, 8'h12, 1, 1));
        rr_tbl.push_back(mk(3'b010, 3'b000, 3'b010, 8'h00, 8'h13, 8'h00, 1, 3'b010, 1, 0, 1, 8'h13, 0, 1));
        rr_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 1));
        rr_tbl.push_back(mk(3'b011, 3'b011, 3'b011, 8'hA0, 8'hB0, 8'h00, 1, 3'b001, 1, 1, 1, 8'hA0, 0, 0));
        rr_tbl.push_back(mk(3'b011, 3'b011, 3'b011, 8'hA1, 8'hB0, 8'h00, 1, 3'b010, 1, 1, 1, 8'hB0, 0, 1));
        rr_tbl.push_back(mk(3'b011, 3'b011, 3'b011, 8'hA1, 8'hB1, 8'h00, 1, 3'b001, 1, 1, 1, 8'hA1, 0, 0));
        rr_tbl.push_back(mk(3'b011, 3'b011, 3'b011, 8'hA2, 8'hB1, 8'h00, 1, 3'b010, 1, 1, 1, 8'hB1, 0, 1));
        rr_tbl.push_back(mk(3'b101, 3'b101, 3'b101, 8'hA2, 8'h00, 8'hC0, 1, 3'b100, 1, 1, 1, 8'hC0, 0, 2));
        rr_tbl.push_back(mk(3'b001, 3'b001, 3'b001, 8'hA2, 8'h00, 8'h00, 1, 3'b001, 1, 1, 1, 8'hA2, 0, 0));
        rr_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 0));
        rr_tbl.push_back(mk(3'b001, 3'b001, 3'b000, 8'h40, 8'h00, 8'h00, 1, 3'b001, 1, 1, 0, 8'h40, 1, 0));
        rr_tbl.push_back(mk(3'b011, 3'b010, 3'b010, 8'h41, 8'h50, 8'h00, 1, 3'b001, 1, 0, 0, 8'h41, 1, 0));
        rr_tbl.push_back(mk(3'b011, 3'b010, 3'b010, 8'h42, 8'h50, 8'h00, 1, 3'b001, 1, 0, 0, 8'h42, 1, 0));
        rr_tbl.push_back(mk(3'b011, 3'b010, 3'b011, 8'h43, 8'h50, 8'h00, 1, 3'b001, 1, 0, 1, 8'h43, 0, 0));
        rr_tbl.push_back(mk(3'b010, 3'b010, 3'b010, 8'h00, 8'h50, 8'h00, 1, 3'b010, 1, 1, 1, 8'h50, 0, 1));
        rr_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 1));
        rr_tbl.push_back(mk(3'b100, 3'b100, 3'b000, 8'h00, 8'h00, 8'hD0, 1, 3'b100, 1, 1, 0, 8'hD0, 1, 2));
        rr_tbl.push_back(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'hD1, 1, 3'b100, 1, 0, 0, 8'hD1, 1, 2));
        rr_tbl.push_back(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'hD2, 0, 3'b100, 1, 0, 0, 8'hD1, 1, 2));
        rr_tbl.push_back(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'hD3, 0, 3'b000, 1, 0, 0, 8'hD1, 1, 2));
        rr_tbl.push_back(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'hD3, 1, 3'b000, 1, 0, 0, 8'hD2, 1, 2));
        rr_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b100, 0, 0, 0, 8'h00, 1, 2));
        rr_tbl.push_back(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'hD3, 1, 3'b100, 1, 0, 0, 8'hD3, 1, 2));
        rr_tbl.push_back(mk(3'b100, 3'b000, 3'b100, 8'h00, 8'h00, 8'hD4, 1, 3'b100, 1, 0, 1, 8'hD4, 0, 2));
        rr_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 2));
        rr_tbl.push_back(mk(3'b010, 3'b000, 3'b000, 8'h00, 8'h77, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 2));
        rr_tbl.push_back(mk(3'b011, 3'b001, 3'b001, 8'h60, 8'h77, 8'h00, 1, 3'b001, 1, 1, 1, 8'h60, 0, 0));

        fp_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 0));
        fp_tbl.push_back(mk(3'b101, 3'b101, 3'b101, 8'h10, 8'h00, 8'h30, 1, 3'b001, 1, 1, 1, 8'h10, 0, 0));
        fp_tbl.push_back(mk(3'b101, 3'b101, 3'b101, 8'h11, 8'h00, 8'h30, 1, 3'b001, 1, 1, 1, 8'h11, 0, 0));
        fp_tbl.push_back(mk(3'b100, 3'b100, 3'b100, 8'h00, 8'h00, 8'h30, 1, 3'b100, 1, 1, 1, 8'h30, 0, 2));
        fp_tbl.push_back(mk(3'b101, 3'b101, 3'b100, 8'h12, 8'h00, 8'h31, 1, 3'b001, 1, 1, 0, 8'h12, 1, 0));
        fp_tbl.push_back(mk(3'b101, 3'b100, 3'b101, 8'h13, 8'h00, 8'h31, 1, 3'b001, 1, 0, 1, 8'h13, 0, 0));
        fp_tbl.push_back(mk(3'b100, 3'b100, 3'b100, 8'h00, 8'h00, 8'h31, 1, 3'b100, 1, 1, 1, 8'h31, 0, 2));
        fp_tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0, 0, 0, 8'h00, 0, 2));

        // Reset state with a live request present.
        rst_n = 1'b0;
        idle_inputs();
        v_in = 3'b001; s_in = 3'b001; e_in = 3'b001; d_in[0] = 8'h99;
        #12;
        check("reset in_ready", 128'(rr_ir), 128'(0));
        check("reset out", 128'({rr_v, rr_s, rr_e, rr_busy, rr_sel, rr_data}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);

        for (int i = 0; i < rr_tbl.size(); i++) begin
            run_vec(rr_tbl[i], $sformatf("rr%0d", i));
        end

        // Async reset in the middle of a packet from port 1.
        run_vec(mk(3'b010, 3'b010, 3'b000, 8'h00, 8'h90, 8'h00, 1, 3'b010, 1, 1, 0, 8'h90, 1, 1),
                "rst_pre");
        @(negedge clk);
        v_in = 3'b010; s_in = 3'b000; d_in[1] = 8'h91;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst rr", 128'({rr_v, rr_busy, rr_ir, rr_sel}), 128'(0));
        check("async rst fp", 128'({fp_v, fp_busy, fp_ir, fp_sel}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        run_vec(mk(3'b111, 3'b111, 3'b111, 8'h20, 8'h21, 8'h22, 1, 3'b001, 1, 1, 1, 8'h20, 0, 0),
                "rst_post");

        use_fp = 1'b1;
        for (int i = 0; i < fp_tbl.size(); i++) begin
            run_vec(fp_tbl[i], $sformatf("fp%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
